// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding, grant constants used by
// both the arbiter and the master multiplexer, and a one-hot sanity helper.
package xbar_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      DRAIN = 2'b10
   } arb_state_t;

   // Grant encodings shared with the mux parameters (two-master build)
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M1   = 2'b01;
   localparam logic [1:0] GRANT_M2   = 2'b10;

   // Widest grant vector the arbiter supports
   localparam int MAX_MASTERS = 4;

   // True when at most one bit of v is set
   function automatic logic onehot0(input logic [MAX_MASTERS-1:0] v);
      return ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/arb_master_rr_chk.sv
// Property checker for arb_master_rr: one-hot grant, busy tracks ownership,
// and the grant never moves while a transaction is in flight.
module arb_master_rr_chk
   import xbar_pkg::*;
#(
   parameter int masters_number = 2
) (
   input logic                      clk,
   input logic                      rst,
   input logic [masters_number-1:0] arb_master_req,
   input logic                      arb_busy
);

   logic [MAX_MASTERS-1:0] gnt_pad_s;

   // Widen the grant so the shared one-hot helper can inspect it
   always_comb begin
      gnt_pad_s = '0;
      gnt_pad_s[masters_number-1:0] = arb_master_req;
   end

   a_onehot : assert property (@(posedge clk) disable iff (!rst)
      onehot0(gnt_pad_s));

   a_busy_owner : assert property (@(posedge clk) disable iff (!rst)
      arb_busy == (arb_master_req != '0));

   a_grant_hold : assert property (@(posedge clk) disable iff (!rst)
      (arb_busy && $past(arb_busy)) |-> $stable(arb_master_req));

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: rotate requests so the slot after ptr sits at bit 0,
// take the lowest set bit, then map the offset back to a master index.
module rr_pick
   import xbar_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     m_req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     win,
   output logic [IDX_W-1:0] win_idx,
   output logic             any_req
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

   logic [IDX_W-1:0] start_s;
   logic [2*N-1:0]   dbl_s;
   logic [N-1:0]     rot_s;
   logic [IDX_W-1:0] off_s;
   logic             found_s;
   logic [IDX_W:0]   sum_s;
   logic [IDX_W-1:0] idx_s;

   // Search starts one past the last winner, wrapping at N
   always_comb begin
      start_s = '0;
      if (ptr == LAST_IDX) begin
         start_s = '0;
      end else begin
         start_s = ptr + IDX_W'(1);
      end
   end

   // Rotate the request vector so the search start lands on bit 0
   always_comb begin
      dbl_s = {m_req, m_req};
      rot_s = dbl_s[start_s +: N];
   end

   // Priority-encode the rotated vector (lowest set bit wins)
   always_comb begin
      off_s   = '0;
      found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found_s && rot_s[i]) begin
            off_s   = IDX_W'(i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Undo the rotation: index = (start + offset) mod N
   always_comb begin
      sum_s = {1'b0, start_s} + {1'b0, off_s};
      idx_s = '0;
      if (sum_s >= N_EXT) begin
         idx_s = IDX_W'(sum_s - N_EXT);
      end else begin
         idx_s = sum_s[IDX_W-1:0];
      end
   end

   // Drive the one-hot winner, its index and the any-request flag
   always_comb begin
      any_req = |m_req;
      win_idx = idx_s;
      win     = '0;
      if (found_s) begin
         win = N'(1) << idx_s;
      end else begin
         win = '0;
      end
   end

endmodule

// File: rtl/arb_master_rr.sv
// Round-robin owner arbiter for the shared slave port. Holds a registered
// one-hot grant from the granting cycle until slave_ack, plus one drain cycle
// so the registered mux can return the ack. Always passes through IDLE between
// owners. Optional watchdog: define ARB_TIMEOUT_EN to release a WAIT that
// lasts TIMEOUT cycles and pulse arb_timeout.
module arb_master_rr
   import xbar_pkg::*;
#(
   parameter int masters_number = 2,
   parameter int TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [masters_number-1:0] m_req,
   input  logic                      slave_ack,
   output logic [masters_number-1:0] arb_master_req,
`ifdef ARB_TIMEOUT_EN
   output logic                      arb_timeout,
`endif
   output logic                      arb_busy
);

   localparam int IDX_W = (masters_number > 1) ? $clog2(masters_number) : 1;
   localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(masters_number - 1);

   // Elaboration-time parameter sanity
   if (masters_number < 2 || masters_number > MAX_MASTERS) begin : g_bad_masters
      $error("arb_master_rr: masters_number must be 2..4");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("arb_master_rr: TIMEOUT must be at least 1");
   end

   arb_state_t                state_r;
   arb_state_t                state_s;
   logic [masters_number-1:0] grant_r;
   logic [masters_number-1:0] grant_s;
   logic [IDX_W-1:0]          ptr_r;
   logic [IDX_W-1:0]          ptr_s;
   logic                      busy_r;
   logic                      busy_s;
   logic [masters_number-1:0] win_s;
   logic [IDX_W-1:0]          win_idx_s;
   logic                      any_req_s;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]          cnt_r;
   logic [CNT_W-1:0]          cnt_s;
   logic [CNT_W-1:0]          cnt_inc_s;
   logic                      timeout_r;
   logic                      timeout_s;
`endif

   rr_pick #(
      .N     (masters_number),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .m_req   (m_req),
      .ptr     (ptr_r),
      .win     (win_s),
      .win_idx (win_idx_s),
      .any_req (any_req_s)
   );

   // Next-state, next-grant, pointer and watchdog decisions
   always_comb begin
      state_s = state_r;
      grant_s = grant_r;
      ptr_s   = ptr_r;
`ifdef ARB_TIMEOUT_EN
      cnt_s     = cnt_r;
      cnt_inc_s = cnt_r + CNT_W'(1);
      timeout_s = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            grant_s = '0;
            if (any_req_s) begin
               grant_s = win_s;
               ptr_s   = win_idx_s;
               state_s = WAIT;
`ifdef ARB_TIMEOUT_EN
               cnt_s   = '0;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            // Ack beats abort and watchdog in the same cycle
            if (slave_ack) begin
               state_s = DRAIN;
            end else if ((grant_r & m_req) == '0) begin
               state_s = IDLE;
               grant_s = '0;
`ifdef ARB_TIMEOUT_EN
            end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
               state_s   = IDLE;
               grant_s   = '0;
               timeout_s = 1'b1;
            end else begin
               cnt_s = cnt_inc_s;
            end
`else
            end else begin
               state_s = WAIT;
            end
`endif
         end
         DRAIN: begin
            state_s = IDLE;
            grant_s = '0;
         end
         default: begin
            state_s = IDLE;
            grant_s = '0;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State, grant, pointer and busy registers with asynchronous reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         grant_r <= '0;
         ptr_r   <= PTR_RST;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         grant_r <= grant_s;
         ptr_r   <= ptr_s;
         busy_r  <= busy_s;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Watchdog counter and timeout pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r     <= '0;
         timeout_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_s;
         timeout_r <= timeout_s;
      end
   end

   assign arb_timeout = timeout_r;
`endif

   assign arb_master_req = grant_r;
   assign arb_busy       = busy_r;

endmodule

// File: tb/tb_arb_master_rr.sv
// Scoreboard bench for arb_master_rr: stimulus pushes each expected grant,
// a negedge monitor pops and compares on every new grant; directed checks
// cover latency, drain, abort, reset and spurious ack.
`timescale 1ns/1ps
module tb_arb_master_rr;
   import xbar_pkg::*;

   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] m_req = '0;
   logic         slave_ack = 1'b0;
   logic [N-1:0] arb_master_req;
   logic         arb_busy;
`ifdef ARB_TIMEOUT_EN
   logic         arb_timeout;
`endif

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_q[$];
   logic [N-1:0] prev_gnt = '0;
   logic [N-1:0] t2_exp [4];

   always #5 clk = ~clk;

   arb_master_rr #(
      .masters_number (N),
      .TIMEOUT        (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .m_req          (m_req),
      .slave_ack      (slave_ack),
      .arb_master_req (arb_master_req),
`ifdef ARB_TIMEOUT_EN
      .arb_timeout    (arb_timeout),
`endif
      .arb_busy       (arb_busy)
   );

   arb_master_rr_chk #(
      .masters_number (N)
   ) u_chk (
      .clk            (clk),
      .rst            (rst),
      .arb_master_req (arb_master_req),
      .arb_busy       (arb_busy)
   );

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every new grant (rising from no owner) is checked against the queue
   always @(negedge clk) begin
      if (!rst) begin
         prev_gnt = '0;
      end else begin
         if (arb_master_req != GRANT_NONE && prev_gnt == GRANT_NONE) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got grant %b expected none", arb_master_req);
            end else begin
               check_val("sb_grant", 32'(arb_master_req), 32'(exp_q.pop_front()));
            end
         end else if (arb_master_req != GRANT_NONE && prev_gnt != arb_master_req) begin
            checks++;
            errors++;
            $display("FAIL sb_back_to_back: got %b after %b expected an idle gap", arb_master_req, prev_gnt);
         end
         prev_gnt = arb_master_req;
      end
   end

   task automatic wait_grant(input string name, input int max_cyc);
      int n = 0;
      while (arb_master_req == GRANT_NONE && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (arb_master_req == GRANT_NONE) begin
         errors++;
         $display("FAIL %s: no grant within %0d cycles, got %b", name, max_cyc, arb_master_req);
      end
   endtask

   // Global time limit
   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
      $fatal(1, "time limit");
   end

   initial begin
      t2_exp = '{GRANT_M1, GRANT_M2, GRANT_M1, GRANT_M2};

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_grant", 32'(arb_master_req), 32'(GRANT_NONE));
      check_val("rst_busy", 32'(arb_busy), 32'd0);
`ifdef ARB_TIMEOUT_EN
      check_val("rst_timeout", 32'(arb_timeout), 32'd0);
`endif
      rst = 1'b1;
      @(negedge clk);

      // T1: single requester master 2, ack at grant+3
      exp_q.push_back(GRANT_M2);
      m_req = 2'b10;
      @(negedge clk);
      check_val("t1_latency", 32'(arb_master_req), 32'(GRANT_M2));
      check_val("t1_busy", 32'(arb_busy), 32'd1);
      repeat (3) begin
         @(negedge clk);
         check_val("t1_hold", 32'(arb_master_req), 32'(GRANT_M2));
      end
      slave_ack = 1'b1;
      @(negedge clk);
      check_val("t1_drain_grant", 32'(arb_master_req), 32'(GRANT_M2));
      check_val("t1_drain_busy", 32'(arb_busy), 32'd1);
      slave_ack = 1'b0;
      m_req = 2'b00;
      @(negedge clk);
      check_val("t1_release", 32'(arb_master_req), 32'(GRANT_NONE));
      check_val("t1_idle_busy", 32'(arb_busy), 32'd0);
      @(negedge clk);

      // T2: contention from reset, alternating grants with an idle gap
      rst = 1'b0;
      @(negedge clk);
      check_val("t2_rst_grant", 32'(arb_master_req), 32'(GRANT_NONE));
      rst = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(t2_exp[k]);
      m_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_grant("t2_wait", 4);
         @(negedge clk);
         slave_ack = 1'b1;
         @(negedge clk);
         check_val("t2_drain", 32'(arb_master_req), 32'(t2_exp[k]));
         slave_ack = 1'b0;
         if (k == 3) m_req = 2'b00;
         @(negedge clk);
         check_val("t2_idle_gap", 32'(arb_master_req), 32'(GRANT_NONE));
      end

      // T3: abort by master 1, then contention favours master 2
      exp_q.push_back(GRANT_M1);
      m_req = 2'b01;
      @(negedge clk);
      check_val("t3_grant", 32'(arb_master_req), 32'(GRANT_M1));
      @(negedge clk);
      m_req = 2'b00;
      @(negedge clk);
      check_val("t3_abort", 32'(arb_master_req), 32'(GRANT_NONE));
      check_val("t3_abort_busy", 32'(arb_busy), 32'd0);
      exp_q.push_back(GRANT_M2);
      m_req = 2'b11;
      @(negedge clk);
      check_val("t3_fair", 32'(arb_master_req), 32'(GRANT_M2));
      slave_ack = 1'b1;
      @(negedge clk);
      slave_ack = 1'b0;
      m_req = 2'b00;
      @(negedge clk);
      check_val("t3_release", 32'(arb_master_req), 32'(GRANT_NONE));

      // T4: asynchronous reset in WAIT
      exp_q.push_back(GRANT_M1);
      m_req = 2'b11;
      @(negedge clk);
      check_val("t4_grant", 32'(arb_master_req), 32'(GRANT_M1));
      #2;
      rst = 1'b0;
      #1;
      check_val("t4_async_grant", 32'(arb_master_req), 32'(GRANT_NONE));
      check_val("t4_async_busy", 32'(arb_busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(GRANT_M1);
      @(negedge clk);
      check_val("t4_after_rst", 32'(arb_master_req), 32'(GRANT_M1));
      slave_ack = 1'b1;
      @(negedge clk);
      slave_ack = 1'b0;
      m_req = 2'b00;
      @(negedge clk);
      check_val("t4_release", 32'(arb_master_req), 32'(GRANT_NONE));

      // T5: spurious ack while idle
      slave_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_val("t5_grant", 32'(arb_master_req), 32'(GRANT_NONE));
         check_val("t5_busy", 32'(arb_busy), 32'd0);
      end
      slave_ack = 1'b0;
      @(negedge clk);

`ifdef ARB_TIMEOUT_EN
      // T6: watchdog release after four WAIT cycles
      exp_q.push_back(GRANT_M1);
      m_req = 2'b01;
      @(negedge clk);
      check_val("t6_grant", 32'(arb_master_req), 32'(GRANT_M1));
      repeat (3) begin
         @(negedge clk);
         check_val("t6_hold", 32'(arb_master_req), 32'(GRANT_M1));
         check_val("t6_no_pulse", 32'(arb_timeout), 32'd0);
      end
      @(negedge clk);
      check_val("t6_expire_grant", 32'(arb_master_req), 32'(GRANT_NONE));
      check_val("t6_pulse", 32'(arb_timeout), 32'd1);
      m_req = 2'b00;
      @(negedge clk);
      check_val("t6_pulse_end", 32'(arb_timeout), 32'd0);

      // T7: ack coincides with expiry, ack wins
      exp_q.push_back(GRANT_M1);
      m_req = 2'b01;
      @(negedge clk);
      repeat (3) @(negedge clk);
      slave_ack = 1'b1;
      @(negedge clk);
      check_val("t7_drain_grant", 32'(arb_master_req), 32'(GRANT_M1));
      check_val("t7_no_pulse", 32'(arb_timeout), 32'd0);
      slave_ack = 1'b0;
      m_req = 2'b00;
      @(negedge clk);
      check_val("t7_release", 32'(arb_master_req), 32'(GRANT_NONE));
      check_val("t7_no_pulse_after", 32'(arb_timeout), 32'd0);
`endif

      repeat (2) @(negedge clk);
      check_val("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
